// File: rtl/ecc_read_sched_pkg.sv
// Shared widths and types for the ECC read scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecc_read_sched_pkg;

  localparam int DATA_WIDTH    = 128;
  localparam int CODE_WIDTH    = 8;
  localparam int ERR_CNT_WIDTH = 16;

  // Response port index is a fixed 2-bit field, so up to 4 requesters.
  localparam int PORT_IDX_W = 2;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [CODE_WIDTH-1:0]    code_t;
  typedef logic [ERR_CNT_WIDTH-1:0] err_cnt_t;

endpackage

// File: rtl/ecc_read_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after last_ptr.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: caller masks req (busy/reset) before it reaches this block.
// Ports: req (per-requester level), last_ptr (previous winner),
//        gnt (one-hot), gnt_idx (index of gnt; equals last_ptr when idle).
module rr_arbiter
  import ecc_read_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  port_idx_t    last_ptr,
  output logic [N-1:0] gnt,
  output port_idx_t    gnt_idx
);

  port_idx_t idx;
  logic      found;

  always_comb begin
    gnt     = '0;
    gnt_idx = last_ptr;
    found   = 1'b0;
    idx     = last_ptr;
    // Walk N positions starting at last_ptr+1 (wrapping at N-1), first hit wins.
    for (int i = 0; i < N; i++) begin
      if (idx == port_idx_t'(N - 1)) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ecc_read_sched.sv
// ECC read scheduler: round-robin read port sharing with SEC correction on return.
// Latency: grant in cycle t, SRAM data in t+1, registered response in t+2.
// Backpressure: sram_busy blocks all grants; a held request is simply re-arbitrated.
// Ports: clk/rst (sync, active-high); rd_req/rd_addr/rd_gnt requester side;
//        sram_busy/sram_rd_en/sram_rd_addr/sram_rd_data/sram_rd_code SRAM side;
//        dec_data/dec_code/dec_cr_data external decoder; ecc_bypass raw return;
//        rsp_valid/rsp_port/rsp_data/rsp_err response; err_cnt/err_cnt_clr counter.
module ecc_read_sched
  import ecc_read_sched_pkg::*;
#(
  parameter int PORT_NUM   = 4,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUM-1:0]            rd_req,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr,
  output logic [PORT_NUM-1:0]            rd_gnt,
  input  logic                           sram_busy,
  output logic                           sram_rd_en,
  output logic [ADDR_WIDTH-1:0]          sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]          sram_rd_data,
  input  logic [CODE_WIDTH-1:0]          sram_rd_code,
  output logic [DATA_WIDTH-1:0]          dec_data,
  output logic [CODE_WIDTH-1:0]          dec_code,
  input  logic [DATA_WIDTH-1:0]          dec_cr_data,
  input  logic                           ecc_bypass,
  output logic                           rsp_valid,
  output logic [PORT_IDX_W-1:0]          rsp_port,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic [ERR_CNT_WIDTH-1:0]       err_cnt,
  input  logic                           err_cnt_clr
);

  // ---------------------------------------------------------------- state
  port_idx_t last_ptr_q, last_ptr_d;
  logic      s1_valid_q, s1_valid_d;
  port_idx_t s1_port_q,  s1_port_d;
  logic      rsp_valid_q, rsp_valid_d;
  port_idx_t rsp_port_q,  rsp_port_d;
  data_t     rsp_data_q,  rsp_data_d;
  logic      rsp_err_q,   rsp_err_d;
  err_cnt_t  err_cnt_q,   err_cnt_d;

  // ---------------------------------------------------------------- arbitration
  logic [PORT_NUM-1:0] req_eff;
  logic [PORT_NUM-1:0] gnt;
  port_idx_t           gnt_idx;
  logic                any_gnt;

  // Reset and write-priority busy both suppress arbitration outright, so the
  // arbiter never sees a request it is not allowed to grant.
  assign req_eff = (rst || sram_busy) ? '0 : rd_req;

  rr_arbiter #(
    .N (PORT_NUM)
  ) u_rr_arbiter (
    .req      (req_eff),
    .last_ptr (last_ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign any_gnt    = |gnt;
  assign rd_gnt     = gnt;
  assign sram_rd_en = any_gnt;

  // One-hot grant makes an OR-mux sufficient; idle address is 0.
  always_comb begin
    sram_rd_addr = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (gnt[p]) begin
        sram_rd_addr = sram_rd_addr | rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------- data return
  // Decoder inputs are zeroed outside a return cycle so it only ever sees
  // real words.
  assign dec_data = s1_valid_q ? sram_rd_data : '0;
  assign dec_code = s1_valid_q ? sram_rd_code : '0;

  logic corr_seen;
  assign corr_seen = !ecc_bypass && (dec_cr_data != sram_rd_data);

  always_comb begin
    last_ptr_d  = any_gnt ? gnt_idx : last_ptr_q;
    s1_valid_d  = any_gnt;
    s1_port_d   = gnt_idx;

    rsp_valid_d = s1_valid_q;
    rsp_port_d  = rsp_port_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    if (s1_valid_q) begin
      rsp_port_d = s1_port_q;
      // ecc_bypass is looked at here, in the data-return cycle.
      rsp_data_d = ecc_bypass ? sram_rd_data : dec_cr_data;
      rsp_err_d  = corr_seen;
    end

    // Count on the same edge that loads an erroneous response; clear wins.
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (rsp_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr_q  <= port_idx_t'(PORT_NUM - 1);
      s1_valid_q  <= 1'b0;
      s1_port_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      last_ptr_q  <= last_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_port_q   <= s1_port_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ecc_read_sched.sv
// Directed bench for ecc_read_sched with an SRAM model and a SEC decoder model.
// Latency: checks grant in t, decoder feed in t+1, response in t+2.
// Backpressure: exercises sram_busy blocking and round-robin re-grant.
module tb_ecc_read_sched;
  import ecc_read_sched_pkg::*;

  localparam int PN = 4;
  localparam int AW = 11;
  localparam logic [AW-1:0] ERR_ADDR = 11'h7FF;

  logic                clk = 1'b0;
  logic                rst;
  logic [PN-1:0]       rd_req;
  logic [PN*AW-1:0]    rd_addr;
  logic [PN-1:0]       rd_gnt;
  logic                sram_busy;
  logic                sram_rd_en;
  logic [AW-1:0]       sram_rd_addr;
  logic [127:0]        sram_rd_data;
  logic [7:0]          sram_rd_code;
  logic [127:0]        dec_data;
  logic [7:0]          dec_code;
  logic [127:0]        dec_cr_data;
  logic                ecc_bypass;
  logic                rsp_valid;
  logic [1:0]          rsp_port;
  logic [127:0]        rsp_data;
  logic                rsp_err;
  logic [15:0]         err_cnt;
  logic                err_cnt_clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ecc_read_sched #(.PORT_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .sram_busy(sram_busy), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .sram_rd_code(sram_rd_code),
    .dec_data(dec_data), .dec_code(dec_code), .dec_cr_data(dec_cr_data),
    .ecc_bypass(ecc_bypass), .rsp_valid(rsp_valid), .rsp_port(rsp_port),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .err_cnt_clr(err_cnt_clr)
  );

  // Code = XOR of (bit position + 1) over all set bits; syndrome names the bad bit.
  function automatic logic [7:0] enc(input logic [127:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 128; i++) begin
      if (d[i]) c = c ^ 8'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [127:0] data_for(input logic [AW-1:0] a);
    return {32'hC0DE_0000 | {21'h0, a}, 32'h1234_5678, 32'h0, 21'h0, a};
  endfunction

  // SRAM model: ERR_ADDR holds a stored zero word whose bit 0 has flipped.
  always @(posedge clk) begin
    if (sram_rd_en) begin
      if (sram_rd_addr == ERR_ADDR) begin
        sram_rd_data <= 128'h1;
        sram_rd_code <= 8'h0;
      end else begin
        sram_rd_data <= data_for(sram_rd_addr);
        sram_rd_code <= enc(data_for(sram_rd_addr));
      end
    end
  end

  // SEC decoder model.
  logic [7:0] syn;
  always_comb begin
    syn         = dec_code ^ enc(dec_data);
    dec_cr_data = dec_data;
    if (syn != 8'd0 && syn <= 8'd128) begin
      dec_cr_data = dec_data ^ (128'h1 << (syn - 8'd1));
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    sram_rd_data = '0;
    sram_rd_code = '0;
    rst = 1'b1; rd_req = '0; rd_addr = '0; sram_busy = 1'b0;
    ecc_bypass = 1'b0; err_cnt_clr = 1'b0;
    for (int p = 0; p < PN; p++) set_addr(p, AW'(11'h10 + p));
    rd_req = 4'b1111;
    repeat (3) tick;

    // Reset state, with requests held.
    check("rst_gnt",       128'(rd_gnt), 128'(0));
    check("rst_rd_en",     128'(sram_rd_en), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_err",   128'(rsp_err), 128'(0));
    check("rst_rsp_port",  128'(rsp_port), 128'(0));
    check("rst_rsp_data",  rsp_data, 128'(0));
    check("rst_err_cnt",   128'(err_cnt), 128'(0));
    check("rst_dec_data",  dec_data, 128'(0));

    // Round-robin order 0,1,2,3,0 with responses two cycles behind.
    rst = 1'b0;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin
        rd_req = '0;
        #1;
      end
      if (c < 5) begin
        check("rr_gnt",  128'(rd_gnt), 128'(1) << order[c]);
        check("rr_addr", 128'(sram_rd_addr), 128'(11'h10 + order[c]));
      end else begin
        check("rr_gnt_idle", 128'(rd_gnt), 128'(0));
      end
      if (c >= 2) begin
        check("rr_rsp_valid", 128'(rsp_valid), 128'(1));
        check("rr_rsp_port",  128'(rsp_port), 128'(order[c-2]));
        check("rr_rsp_data",  rsp_data, data_for(AW'(11'h10 + order[c-2])));
        check("rr_rsp_err",   128'(rsp_err), 128'(0));
      end else begin
        check("rr_rsp_early", 128'(rsp_valid), 128'(0));
      end
      tick;
    end
    check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    check("idle_rsp_err",   128'(rsp_err), 128'(0));
    check("idle_rsp_port",  128'(rsp_port), 128'(0));
    check("idle_rsp_data",  rsp_data, data_for(11'h10));

    // Single-bit error on port 2, corrected by the decoder.
    set_addr(2, ERR_ADDR);
    rd_req = 4'b0100;
    #1;
    check("err_gnt",  128'(rd_gnt), 128'(4'b0100));
    check("err_addr", 128'(sram_rd_addr), 128'(ERR_ADDR));
    tick;
    rd_req = '0;
    check("err_dec_data", dec_data, 128'h1);
    check("err_dec_code", 128'(dec_code), 128'(0));
    tick;
    check("err_rsp_valid", 128'(rsp_valid), 128'(1));
    check("err_rsp_port",  128'(rsp_port), 128'(2));
    check("err_rsp_data",  rsp_data, 128'(0));
    check("err_rsp_err",   128'(rsp_err), 128'(1));
    check("err_cnt_1",     128'(err_cnt), 128'(1));
    check("err_dec_idle",  dec_data, 128'(0));

    // sram_busy blocks grants; pointer (now 2) must not move meanwhile.
    set_addr(2, 11'h12);
    sram_busy = 1'b1;
    rd_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_gnt",   128'(rd_gnt), 128'(0));
      check("busy_rd_en", 128'(sram_rd_en), 128'(0));
      tick;
    end
    sram_busy = 1'b0;
    #1;
    check("busy_rel_gnt", 128'(rd_gnt), 128'(4'b0100));
    tick;
    rd_req = 4'b1111;
    sram_busy = 1'b1;
    #1;
    check("busy_all_gnt", 128'(rd_gnt), 128'(0));
    tick;
    sram_busy = 1'b0;
    #1;
    check("busy_ptr_kept", 128'(rd_gnt), 128'(4'b1000));
    check("busy_rsp_port", 128'(rsp_port), 128'(2));
    tick;
    rd_req = '0;
    check("busy_bubble", 128'(rsp_valid), 128'(0));
    tick;
    check("busy_rsp3_v", 128'(rsp_valid), 128'(1));
    check("busy_rsp3_p", 128'(rsp_port), 128'(3));

    // Bypass sampled in the return cycle, not the grant cycle.
    set_addr(1, ERR_ADDR);
    rd_req = 4'b0010;
    ecc_bypass = 1'b0;
    #1;
    check("byp_gnt", 128'(rd_gnt), 128'(4'b0010));
    tick;
    rd_req = '0;
    ecc_bypass = 1'b1;
    tick;
    check("byp_rsp_valid", 128'(rsp_valid), 128'(1));
    check("byp_rsp_data",  rsp_data, 128'h1);
    check("byp_rsp_err",   128'(rsp_err), 128'(0));
    check("byp_err_cnt",   128'(err_cnt), 128'(1));
    rd_req = 4'b0010;
    tick;
    rd_req = '0;
    ecc_bypass = 1'b0;
    tick;
    check("nobyp_rsp_data", rsp_data, 128'(0));
    check("nobyp_rsp_err",  128'(rsp_err), 128'(1));
    check("nobyp_err_cnt",  128'(err_cnt), 128'(2));

    // Reset in the cycle after a grant discards the read.
    set_addr(1, 11'h11);
    rd_req = 4'b0001;
    #1;
    check("rstf_gnt", 128'(rd_gnt), 128'(4'b0001));
    tick;
    rd_req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstf_err_cnt", 128'(err_cnt), 128'(0));
    check("rstf_valid0",  128'(rsp_valid), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rstf_valid", 128'(rsp_valid), 128'(0));
    end

    // Saturation: 65534 errors, then three more, then clear racing an increment.
    for (int p = 0; p < PN; p++) set_addr(p, ERR_ADDR);
    rd_req = 4'b1111;
    repeat (65534) tick;
    rd_req = '0;
    tick;
    tick;
    check("sat_fffe", 128'(err_cnt), 128'(16'hFFFE));
    rd_req = 4'b0001;
    tick;
    rd_req = '0;
    tick;
    check("sat_ffff", 128'(err_cnt), 128'(16'hFFFF));
    rd_req = 4'b1111;
    tick;
    tick;
    rd_req = '0;
    tick;
    tick;
    check("sat_hold",     128'(err_cnt), 128'(16'hFFFF));
    check("sat_rsp_data", rsp_data, 128'(0));
    rd_req = 4'b0001;
    tick;
    rd_req = '0;
    err_cnt_clr = 1'b1;
    tick;
    err_cnt_clr = 1'b0;
    check("clr_err_cnt",   128'(err_cnt), 128'(0));
    check("clr_rsp_err",   128'(rsp_err), 128'(1));
    check("clr_rsp_valid", 128'(rsp_valid), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
